// File: rtl/arb_pkg.sv
// Shared types and the round-robin search for the arbiter.
// The search is written for up to MAX_REQ requesters.
package arb_pkg;

   localparam int unsigned MAX_REQ   = 32;
   localparam int unsigned MAX_IDX_W = 5;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_e;

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } pick_t;

   // First set bit at or above ptr, wrapping at n-1 back to 0.
   function automatic pick_t rr_pick(
      input logic [MAX_REQ-1:0] req,
      input int unsigned        n,
      input int unsigned        ptr
   );
      pick_t       p;
      int unsigned j;
      p = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (i < n) begin
            j = ptr + i;
            if (j >= n) j = j - n;
            if (!p.found && req[j]) begin
               p.found = 1'b1;
               p.idx   = MAX_IDX_W'(j);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The arbiter takes the slave side.
interface rr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int IDX_W  = $clog2(N_REQ),
   parameter int HOLD_W = 4
);

   logic              en_i;
   logic [N_REQ-1:0]  req_i;
   logic              beat_i;
   logic [N_REQ-1:0]  gnt_o;
   logic              gnt_valid_o;
   logic [IDX_W-1:0]  gnt_idx_o;
   logic [HOLD_W-1:0] hold_cnt_o;
   logic              expired_o;

   modport master (
      output en_i,
      output req_i,
      output beat_i,
      input  gnt_o,
      input  gnt_valid_o,
      input  gnt_idx_o,
      input  hold_cnt_o,
      input  expired_o
   );

   modport slave (
      input  en_i,
      input  req_i,
      input  beat_i,
      output gnt_o,
      output gnt_valid_o,
      output gnt_idx_o,
      output hold_cnt_o,
      output expired_o
   );

endinterface

// File: rtl/rr_arbiter_ptr.sv
// Round-robin search pointer: wraps 0..N_REQ-1.
// Loads owner+1 when the current grant is released.
module rr_ptr #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             ld_i,
   input  logic [IDX_W-1:0] owner_i,
   output logic [IDX_W-1:0] ptr_o
);

   logic [IDX_W-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (ld_i) begin
         if (owner_i == IDX_W'(N_REQ - 1)) ptr_d = '0;
         else ptr_d = owner_i + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a per-grant beat limit.
// Grants are registered; one idle cycle separates grants.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDX_W    = $clog2(N_REQ),
   parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
   input logic         clk_i,
   input logic         arst_ni,
   rr_arbiter_if.slave bus
);

   arb_state_e        state_d, state_q;
   logic [N_REQ-1:0]  gnt_d, gnt_q;
   logic [IDX_W-1:0]  idx_d, idx_q;
   logic [HOLD_W-1:0] hold_d, hold_q;
   logic              exp_d, exp_q;
   logic [IDX_W-1:0]  ptr;
   logic              ptr_ld;
   pick_t             pick;
   logic              req_own;
   logic              last_beat;
   logic              release_c;

   rr_ptr #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_ptr (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .ld_i    (ptr_ld),
      .owner_i (idx_q),
      .ptr_o   (ptr)
   );

   always_comb begin
      pick      = rr_pick(MAX_REQ'(bus.req_i), N_REQ, 32'(ptr));
      req_own   = bus.req_i[idx_q];
      last_beat = bus.beat_i &&
                  (hold_q == HOLD_W'(MAX_HOLD - 1));
      release_c = !req_own || last_beat || !bus.en_i;

      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      exp_d   = 1'b0;
      ptr_ld  = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (bus.en_i && pick.found) begin
               for (int i = 0; i < N_REQ; i++)
                  gnt_d[i] = (pick.idx == MAX_IDX_W'(i));
               idx_d   = IDX_W'(pick.idx);
               hold_d  = '0;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (release_c) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               idx_d   = '0;
               hold_d  = '0;
               ptr_ld  = 1'b1;
               // A drop of the request wins over the limit.
               exp_d   = last_beat && req_own;
            end else if (bus.beat_i) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         exp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         exp_q   <= exp_d;
      end
   end

   assign bus.gnt_o       = gnt_q;
   assign bus.gnt_valid_o = |gnt_q;
   assign bus.gnt_idx_o   = idx_q;
   assign bus.hold_cnt_o  = hold_q;
   assign bus.expired_o   = exp_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomized and directed bench for rr_arbiter against
// an integer-level model of the arbitration rules.
module tb_rr_arbiter;

   localparam int N    = 4;
   localparam int MAXH = 8;
   localparam int IW   = $clog2(N);
   localparam int HW   = $clog2(MAXH + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   int owner_m = -1;
   int ptr_m   = 0;
   int hold_m  = 0;
   bit exp_m   = 1'b0;
   int exp_cnt_m;
   int exp_cnt_d;

   rr_arbiter_if #(.N_REQ(N), .IDX_W(IW), .HOLD_W(HW)) bus ();

   rr_arbiter #(
      .N_REQ    (N),
      .MAX_HOLD (MAXH)
   ) dut (
      .clk_i   (clk),
      .arst_ni (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner_m = -1;
      ptr_m   = 0;
      hold_m  = 0;
      exp_m   = 1'b0;
   endtask

   task automatic model_tick(input bit e,
                             input logic [3:0] r,
                             input bit b);
      bit a, lim;
      if (owner_m < 0) begin
         exp_m = 1'b0;
         if (e) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (ptr_m + k) % N;
               if (owner_m < 0 && r[c]) owner_m = c;
            end
            hold_m = 0;
         end
      end else begin
         a   = !r[owner_m];
         lim = b && (hold_m == MAXH - 1);
         if (a || lim || !e) begin
            exp_m   = lim && !a;
            ptr_m   = (owner_m + 1) % N;
            owner_m = -1;
            hold_m  = 0;
         end else begin
            exp_m = 1'b0;
            if (b) hold_m++;
         end
      end
   endtask

   task automatic check_all();
      logic [31:0] eg, ei;
      eg = (owner_m < 0) ? 32'd0 : (32'd1 << owner_m);
      ei = (owner_m < 0) ? 32'd0 : 32'(owner_m);
      chk("gnt", 32'(bus.gnt_o), eg);
      chk("gnt_valid", 32'(bus.gnt_valid_o), 32'(owner_m >= 0));
      chk("gnt_idx", 32'(bus.gnt_idx_o), ei);
      chk("hold_cnt", 32'(bus.hold_cnt_o), 32'(hold_m));
      chk("expired", 32'(bus.expired_o), 32'(exp_m));
   endtask

   task automatic step(input bit e,
                       input logic [3:0] r,
                       input bit b);
      bus.en_i   = e;
      bus.req_i  = r;
      bus.beat_i = b;
      @(posedge clk);
      model_tick(e, r, b);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      bus.en_i   = 1'b0;
      bus.req_i  = '0;
      bus.beat_i = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] r;
      bit         e, b;

      do_reset();

      // Async reset mid-grant with a stale pointer of 2.
      step(1, 4'b0010, 0);
      step(1, 4'b0000, 0);
      step(1, 4'b0110, 0);
      chk("pre_reset_idx", 32'(bus.gnt_idx_o), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
      chk("rst_valid", 32'(bus.gnt_valid_o), 32'd0);
      chk("rst_idx", 32'(bus.gnt_idx_o), 32'd0);
      chk("rst_hold", 32'(bus.hold_cnt_o), 32'd0);
      chk("rst_exp", 32'(bus.expired_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 4'b0110, 0);
      chk("post_reset_idx", 32'(bus.gnt_idx_o), 32'd1);

      // Fair rotation: each owner drops after two beats.
      do_reset();
      for (int g = 0; g < 5; g++) begin
         step(1, 4'b1111, 1);
         chk("rot_order", 32'(bus.gnt_idx_o), 32'(g % N));
         step(1, 4'b1111, 1);
         step(1, 4'b1111, 1);
         step(1, 4'b1111 & ~(4'b1 << (g % N)), 0);
         chk("rot_noexp", 32'(bus.expired_o), 32'd0);
      end

      // Pointer wrap after owner 3.
      step(1, 4'b0000, 0);
      step(1, 4'b1000, 0);
      step(1, 4'b0000, 0);
      step(1, 4'b1001, 0);
      chk("wrap_idx", 32'(bus.gnt_idx_o), 32'd0);
      step(1, 4'b0000, 0);

      // Single requester hitting the hold limit.
      exp_cnt_m = 0;
      exp_cnt_d = 0;
      for (int i = 0; i < 30; i++) begin
         step(1, 4'b0100, 1);
         exp_cnt_m += int'(exp_m);
         exp_cnt_d += int'(bus.expired_o);
      end
      chk("single_exp_cnt", 32'(exp_cnt_d), 32'(exp_cnt_m));
      step(1, 4'b0000, 0);
      step(1, 4'b0000, 0);

      // Enable drop during a grant to 1.
      step(1, 4'b0010, 0);
      chk("en_grant", 32'(bus.gnt_idx_o), 32'd1);
      step(0, 4'b0010, 1);
      chk("en_drop_gnt", 32'(bus.gnt_o), 32'd0);
      chk("en_drop_exp", 32'(bus.expired_o), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(0, 4'b0110, 0);
         chk("en_low_idle", 32'(bus.gnt_valid_o), 32'd0);
      end
      step(1, 4'b0100, 0);
      chk("en_regrant", 32'(bus.gnt_idx_o), 32'd2);
      step(1, 4'b0000, 0);
      step(1, 4'b0000, 0);

      // Request drop coinciding with the 8th beat.
      step(1, 4'b0001, 0);
      for (int i = 0; i < 7; i++) step(1, 4'b0001, 1);
      chk("sim_hold7", 32'(bus.hold_cnt_o), 32'd7);
      step(1, 4'b0000, 1);
      chk("sim_exp", 32'(bus.expired_o), 32'd0);
      chk("sim_rel", 32'(bus.gnt_valid_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1, 4'b0000, 1);
         chk("idle_beat_hold", 32'(bus.hold_cnt_o), 32'd0);
      end

      // Random traffic with slowly changing requests.
      r = 4'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         e = ($urandom_range(0, 7) != 0);
         b = ($urandom_range(0, 3) != 0);
         step(e, r, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one counter/datapath resource among `N_REQ` requesters. It grants one requester at a time and holds the grant while that requester keeps its request asserted. A hold counter bounds the grant to `MAX_HOLD` beats, which enforces fairness. It sits in front of the shared counter/FIFO datapath and drives its owner-select and enable.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `MAX_HOLD`, 8: maximum beats per grant, ≥1.
- `IDX_W`, `$clog2(N_REQ)`: width of the grant index.
- `HOLD_W`, `$clog2(MAX_HOLD+1)`: width of the hold counter.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `arst_ni`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  arbiter enable; low blocks new grants and revokes the current grant.
- `req_i`  in  `N_REQ`  per-requester request, level-sensitive.
- `beat_i`  in  1  the grant owner completed one transfer this cycle.
- `gnt_o`  out  `N_REQ`  one-hot grant, all-zero when idle.
- `gnt_valid_o`  out  1  OR of `gnt_o`.
- `gnt_idx_o`  out  `IDX_W`  index of the owner; 0 when idle.
- `hold_cnt_o`  out  `HOLD_W`  beats consumed in the current grant.
- `expired_o`  out  1  one-cycle pulse when a grant is revoked by the `MAX_HOLD` limit.

## Operation
- **Reset values:** state `IDLE`, `ptr`=0, `gnt_o`=0, `gnt_valid_o`=0, `gnt_idx_o`=0, `hold_cnt_o`=0, `expired_o`=0.
- **IDLE:**
  - If `en_i`=1 and `req_i`≠0, pick the first set bit searching upward from `ptr`, wrapping from `N_REQ-1` to 0.
  - Register the winner into `gnt_o`/`gnt_idx_o`, clear the hold counter, and go to `GRANT`.
  - Otherwise stay in `IDLE`.
- **GRANT:**
  - Each cycle with `beat_i`=1, the hold counter increments by 1.
  - `beat_i` is ignored in `IDLE`.
  - A release occurs when any of the following is true. They are evaluated in the same cycle and OR-ed:
    - (a) `req_i[owner]`=0;
    - (b) `beat_i`=1 and hold count = `MAX_HOLD-1`, i.e. this beat is the `MAX_HOLD`-th;
    - (c) `en_i`=0.
- **On release:**
  - Go to `IDLE`.
  - Clear `gnt_o`, `gnt_idx_o` and the hold counter.
  - Set `ptr` to owner+1, wrapping at `N_REQ-1` → 0.
  - Set `expired_o`=1 for one cycle only if (b) held and (a) did not.
- The pointer advances only on release, never in `IDLE`, so a requester that is skipped is never starved.
- At most one bit of `gnt_o` is set at any time.
- `gnt_o` changes only in the registered state update; no combinational path runs from `req_i` to `gnt_o`.
- The hold counter never exceeds `MAX_HOLD-1` while in `GRANT` and never wraps.

## Timing
- **Request to grant:** a request that first appears in cycle t while in `IDLE` produces `gnt_o` high from cycle t+1.
- **Release:** a release condition in cycle t makes `gnt_o` low in cycle t+1. `expired_o` is high in cycle t+1 only.
- **Minimum gap:** there is exactly one idle cycle between consecutive grants, including grants to the same requester. The earliest re-grant is at t+2.
- **Hold count:** `hold_cnt_o` reflects beats up to the previous cycle, as a registered value.
- **Beat on release cycle:** a beat in the same cycle as a request drop is still counted as consumed by the datapath. The count is then cleared.
- **`en_i` low for several cycles:** no grant is issued; `ptr` is unchanged after the first release.
- **Reset mid-grant:** everything returns immediately to the reset values, asynchronously. The next grant starts the search at index 0.
- **`MAX_HOLD`=1:** every beat releases the grant, giving strict per-beat round-robin.

## Structure
- Package `arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e`;
  - a function `rr_pick(req, ptr)` that returns the winner index and a found flag.
- Sub-module `rr_ptr`: a wrapping index counter 0..`N_REQ-1` with a load-enable. It advances to owner+1 on release and resets to 0.
- The hold counter and the FSM live in `rr_arbiter`.

## Test plan
- **Reset:** assert `arst_ni`=0 mid-grant with `req_i`=4'b0010. All outputs go to 0 at once. After release of reset, `gnt_idx_o`=1 two edges later, with the search starting from index 0.
- **Single requester:** `req_i`=4'b0100 held and `beat_i`=1 every cycle, `MAX_HOLD`=8.
  - `gnt_o`=4'b0100 for 8 cycles, then `expired_o` pulses and `gnt_o`=0 for 1 cycle.
  - It is re-granted to 2; the pointer wraps past 3 and 0 back to 2.
- **Fair rotation:** `req_i`=4'b1111 held, each owner drops its request after 2 beats. The grant order is 0,1,2,3,0, with a 1-cycle gap each time and `expired_o` never asserted.
- **Pointer wrap:** last owner 3, then `req_i`=4'b1001. The grant goes to 0, not 3.
- **Enable drop:** `en_i`→0 during a grant to 1. `gnt_o`=0 the next cycle with no `expired_o`. With `en_i`=0 held for 5 cycles, no grant is issued. Re-enabling grants 2 if `req_i`[2]=1.
- **Simultaneous release causes:** the request drops on the 8th beat. The grant is released and `expired_o` stays 0. `beat_i` pulses in `IDLE` leave `hold_cnt_o`=0.
